font_rom_arbiter: RTL and testbench
===================================

Name: font_rom_arbiter

Overview:
- Shares the single synchronous font ROM among up to four text requesters: score, logo, rule and game-over overlays.
- Two-level selection: a priority mask picks the high-priority requesters, and round-robin applies inside the chosen level.
- Registered grant, ROM address and tagged response; fixed two-cycle latency from request sample to response.
- Sits between the text generator's per-region lookup logic and the font ROM, in the CLK_50MHZ domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- AW, 11, ROM address width ({char[6:0], row[3:0]}).
- DW, 8, ROM data width (one glyph row).

Ports:
- CLK_50MHZ  in  1  clock.
- reset  in  1  asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse at pixel (0,0); resets the round-robin pointer.
- req  in  N_REQ  per-requester request level; held until the matching gnt.
- req_addr  in  N_REQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- prio_mask  in  N_REQ  1 = requester i is high priority.
- gnt  out  N_REQ  one-hot one-cycle grant pulse (registered).
- rom_addr  out  AW  registered address to the font ROM.
- rom_data  in  DW  ROM output, valid one cycle after rom_addr.
- rsp_valid  out  1  response strobe.
- rsp_id  out  3  index of the requester answered.
- rsp_data  out  DW  glyph row returned.
- conflict  out  1  pulse when more than one request was eligible on an arbitration edge.

Behaviour:
- Reset (asynchronous): gnt=0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_data=0, conflict=0, rr_ptr=0, pipeline valid bits=0.
- Eligibility: elig[i] = req[i] & ~gnt[i]. A requester is never granted twice in consecutive cycles. Requesters must clear req on the edge on which they see gnt.
- Level select: if (elig & prio_mask) != 0, candidates = elig & prio_mask; otherwise candidates = elig.
- Winner: the first set candidate scanning i = rr_ptr, rr_ptr+1, ..., wrapping modulo N_REQ.
- Edge N, if any candidate exists:
  - gnt <= onehot(winner); rom_addr <= req_addr[winner]; s1_valid <= 1; s1_id <= winner; rr_ptr <= (winner+1) mod N_REQ.
- Edge N, if no candidate: gnt <= 0; s1_valid <= 0; rom_addr and rr_ptr hold.
- Edge N+1: rom_data is valid. On edge N+2: rsp_valid <= s1_valid, rsp_id <= s1_id, rsp_data <= rom_data. rsp_valid is therefore a one-cycle pulse per grant.
- Throughput: one grant per cycle whenever at least one eligible request exists. Back-to-back responses from different requesters are supported.
- conflict <= (popcount(elig) >= 2), registered on the same edge as gnt.
- frame_tick: rr_ptr <= 0 and takes priority over the pointer update. A grant issued on the same edge is still issued normally.
- Pipeline: in-flight responses are never dropped by frame_tick or by changes to prio_mask or req.
- prio_mask change: takes effect on the next arbitration edge. No state depends on its old value.
- Reset mid-operation: pending responses are discarded and all outputs return to their reset values immediately.
- Bounded wait: a requester whose priority level stays fixed and holds req is granted within N_REQ eligible arbitration edges, provided no other request in the same level is starved by the higher level.

Decomposition:
- Shared package (font_pkg): AW, DW and the requester index constants (REQ_SCORE=0, REQ_LOGO=1, REQ_RULE=2, REQ_OVER=3).
- Sub-module rr_pick: combinational round-robin one-hot picker (inputs: candidates, ptr; output: winner index and valid). It is instantiated once.
- The top level holds the level-select logic, the registers and the response pipeline.

Test Plan:
- Single requester: req=4'b0001, addr0=11'h2A3, prio_mask=0. Expect gnt=0001 on the next edge, rom_addr=11'h2A3, then rsp_valid=1, rsp_id=0, rsp_data=ROM[11'h2A3] two edges after sampling.
- All four requesting continuously (re-raised after each gnt), prio_mask=0, starting from reset. Expect grant order 0,1,2,3,0,... and conflict=1 on each edge with two or more eligible requests.
- prio_mask=4'b1000 with req=4'b1111 held: requester 3 wins first. While it is in its post-grant cycle, req 0 wins. Requester 3 wins again whenever eligible; requesters 1 and 2 wait until no high-priority request is eligible.
- Pointer reset: after winner 2 (rr_ptr=3), assert frame_tick with req=4'b1001. Expect grant 3 on that edge, then rr_ptr=0 so requester 0 wins next.
- Reset mid-pipeline: assert reset one cycle after a grant. Expect rsp_valid to stay 0, gnt=0 and rom_addr=0 immediately, and no response after release.
- Idle: req=0 for 10 cycles. Expect gnt=0, rsp_valid=0 and rom_addr unchanged throughout.

Source files
------------

// File: rtl/font_pkg.sv
`default_nettype none
// ============================================================================
// Module      : font_pkg
// Description : Shared constants for the font ROM arbitration slice.
//               AW / DW describe the font ROM ({char[6:0], row[3:0]} address,
//               one glyph row of data). REQ_* name the requester slots used by
//               the text generator overlays.
// Revision    : 1.0 - initial release
// ============================================================================
package font_pkg;

  // Font ROM geometry
  localparam int AW = 11;
  localparam int DW = 8;

  // Width of the response tag carried back to the requesters
  localparam int ID_W = 3;

  // Largest supported requester count
  localparam int MAX_REQ = 8;

  // Requester slot assignment
  localparam int REQ_SCORE = 0;
  localparam int REQ_LOGO  = 1;
  localparam int REQ_RULE  = 2;
  localparam int REQ_OVER  = 3;

  // Number of set bits in a request vector (zero-extended to MAX_REQ bits)
  function automatic logic [3:0] count_ones(input logic [MAX_REQ-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage : font_pkg
`default_nettype wire

// File: rtl/font_rom_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the index of the
//               first set bit of 'cand' when scanning upward from 'ptr' and
//               wrapping modulo N_REQ.
// Ports       : cand   in  N_REQ  candidate vector
//               ptr    in  IW     scan start index (always < N_REQ)
//               winner out IW     index of the selected candidate
//               valid  out 1      at least one candidate is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import font_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] cand,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             valid
);

  localparam logic [IW:0] C_N = (IW+1)'(N_REQ);

  // Scan offsets from the far end down to zero so that the smallest offset
  // from ptr is the last assignment and therefore the one that sticks.
  always_comb begin
    logic [IW:0] idx;
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IW+1)'(k);
      if (idx >= C_N) begin
        idx = idx - C_N;
      end
      if (cand[idx[IW-1:0]]) begin
        valid  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/font_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : font_rom_arbiter
// Description : Shares one synchronous font ROM between up to N_REQ text
//               overlay requesters. Two-level selection: requesters flagged in
//               prio_mask win over the rest, round-robin inside the level.
//               Grant, ROM address and tagged response are registered; the
//               response appears two edges after the arbitration edge.
// Ports       : CLK_50MHZ  in   1        clock
//               reset      in   1        asynchronous, active-high
//               frame_tick in   1        start-of-frame pulse, clears rr_ptr
//               req        in   N_REQ    request levels
//               req_addr   in   N_REQ*AW flattened per-requester addresses
//               prio_mask  in   N_REQ    1 = high-priority requester
//               gnt        out  N_REQ    one-hot one-cycle grant
//               rom_addr   out  AW       address to the font ROM
//               rom_data   in   DW       ROM data, one cycle after rom_addr
//               rsp_valid  out  1        response strobe
//               rsp_id     out  3        requester being answered
//               rsp_data   out  DW       glyph row
//               conflict   out  1        two or more requests were eligible
// Revision    : 1.0 - initial release
// ============================================================================
module font_rom_arbiter
  import font_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int AW    = font_pkg::AW,
  parameter int DW    = font_pkg::DW
) (
  input  logic                CLK_50MHZ,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ-1:0]    prio_mask,
  output logic [N_REQ-1:0]    gnt,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_data,
  output logic                rsp_valid,
  output logic [2:0]          rsp_id,
  output logic [DW-1:0]       rsp_data,
  output logic                conflict
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] C_LAST = IW'(N_REQ - 1);

  // --------------------------------------------------------------------------
  // Level select
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] elig_hi;
  logic [N_REQ-1:0] cand;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    winner;
  logic             win_valid;
  logic [AW-1:0]    win_addr;
  logic [IW-1:0]    ptr_next;
  logic             multi_elig;

  // A requester that was granted last edge is still showing req this cycle
  // (it drops req on the grant edge); masking with gnt keeps it from being
  // granted a second time.
  assign elig    = req & ~gnt;
  assign elig_hi = elig & prio_mask;
  assign cand    = (|elig_hi) ? elig_hi : elig;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .cand   (cand),
    .ptr    (rr_ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  assign win_addr   = req_addr[int'(winner)*AW +: AW];
  assign multi_elig = (count_ones(MAX_REQ'(elig)) >= 4'd2);

  // Pointer moves just past the winner; frame_tick overrides any update.
  always_comb begin
    ptr_next = rr_ptr;
    if (frame_tick) begin
      ptr_next = '0;
    end else if (win_valid) begin
      ptr_next = (winner == C_LAST) ? '0 : winner + IW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration registers
  // --------------------------------------------------------------------------
  logic         s1_valid;
  logic [2:0]   s1_id;

  always_ff @(posedge CLK_50MHZ or posedge reset) begin
    if (reset) begin
      gnt      <= '0;
      rom_addr <= '0;
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      conflict <= 1'b0;
    end else begin
      rr_ptr   <= ptr_next;
      conflict <= multi_elig;
      s1_valid <= win_valid;
      if (win_valid) begin
        gnt      <= N_REQ'(1) << winner;
        rom_addr <= win_addr;
        s1_id    <= 3'(winner);
      end else begin
        gnt      <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response pipeline
  // Stage s1 is aligned with rom_addr, stage s2 with the ROM's registered
  // output; the response register samples rom_data while s2 is valid.
  // --------------------------------------------------------------------------
  logic       s2_valid;
  logic [2:0] s2_id;

  always_ff @(posedge CLK_50MHZ or posedge reset) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_id     <= s1_id;
      rsp_valid <= s2_valid;
      if (s2_valid) begin
        rsp_id   <= s2_id;
        rsp_data <= rom_data;
      end
    end
  end

endmodule : font_rom_arbiter
`default_nettype wire

// File: tb/tb_font_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_font_rom_arbiter
// Description : Scoreboard bench for font_rom_arbiter. Directed vectors push
//               expected grants and responses into queues; a negedge monitor
//               pops and compares whenever the DUT presents gnt or rsp_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_font_rom_arbiter;
  import font_pkg::*;

  localparam int N = 4;

  logic              CLK_50MHZ = 1'b0;
  logic              reset;
  logic              frame_tick;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      prio_mask;
  logic [N-1:0]      gnt;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              conflict;

  int tests = 0;
  int fails = 0;

  logic [AW-1:0] addr_tab [N];

  typedef struct { int id; logic [AW-1:0] addr; logic conf; } gnt_exp_t;
  typedef struct { int id; logic [DW-1:0] data; } rsp_exp_t;
  gnt_exp_t gq[$];
  rsp_exp_t rq[$];

  always #10 CLK_50MHZ = ~CLK_50MHZ;

  font_rom_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .CLK_50MHZ  (CLK_50MHZ),
    .reset      (reset),
    .frame_tick (frame_tick),
    .req        (req),
    .req_addr   (req_addr),
    .prio_mask  (prio_mask),
    .gnt        (gnt),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .conflict   (conflict)
  );

  // Font ROM stand-in: synchronous, arbitrary but address-dependent contents
  function automatic logic [7:0] rom_f(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], a[4:0]} ^ 8'h5A;
  endfunction

  always @(posedge CLK_50MHZ) rom_data <= rom_f(rom_addr);

  initial begin
    addr_tab[REQ_SCORE] = 11'h2A3;
    addr_tab[REQ_LOGO]  = 11'h155;
    addr_tab[REQ_RULE]  = 11'h7FE;
    addr_tab[REQ_OVER]  = 11'h0C4;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = addr_tab[i];
  end

  // Monitor: compare every presented grant / response against the queues
  always @(negedge CLK_50MHZ) begin
    gnt_exp_t ge;
    rsp_exp_t re;
    if (!reset) begin
      if (gnt != '0) begin
        tests++;
        if (gq.size() == 0) begin
          fails++;
          $display("FAIL grant: unexpected gnt=%b", gnt);
        end else begin
          ge = gq.pop_front();
          if (gnt !== (4'b0001 << ge.id) || rom_addr !== ge.addr || conflict !== ge.conf) begin
            fails++;
            $display("FAIL grant: got gnt=%b addr=%h conflict=%b, expected id=%0d addr=%h conflict=%b",
                     gnt, rom_addr, conflict, ge.id, ge.addr, ge.conf);
          end
        end
      end else if (conflict) begin
        tests++;
        fails++;
        $display("FAIL conflict_without_grant: got conflict=1 expected 0");
      end
      if (rsp_valid) begin
        tests++;
        if (rq.size() == 0) begin
          fails++;
          $display("FAIL response: unexpected rsp id=%0d data=%h", rsp_id, rsp_data);
        end else begin
          re = rq.pop_front();
          if (rsp_id !== 3'(re.id) || rsp_data !== re.data) begin
            fails++;
            $display("FAIL response: got id=%0d data=%h expected id=%0d data=%h",
                     rsp_id, rsp_data, re.id, re.data);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one arbitration edge; gid < 0 means no grant expected
  task automatic cyc(input logic [3:0] r, input logic [3:0] p, input logic f,
                     input int gid, input logic conf, input logic with_rsp);
    req = r; prio_mask = p; frame_tick = f;
    if (gid >= 0) begin
      gq.push_back(gnt_exp_t'{gid, addr_tab[gid], conf});
      if (with_rsp) rq.push_back(rsp_exp_t'{gid, rom_f(addr_tab[gid])});
    end
    @(posedge CLK_50MHZ); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0000, 4'b0000, 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; prio_mask = '0; frame_tick = 1'b0;
    #1;
    chk("reset_gnt",       32'(gnt),       32'd0);
    chk("reset_rom_addr",  32'(rom_addr),  32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_id",    32'(rsp_id),    32'd0);
    chk("reset_rsp_data",  32'(rsp_data),  32'd0);
    chk("reset_conflict",  32'(conflict),  32'd0);
    repeat (2) @(posedge CLK_50MHZ);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] held;
    reset = 1'b1; req = '0; prio_mask = '0; frame_tick = 1'b0;
    repeat (2) @(posedge CLK_50MHZ);
    #1;
    do_reset();

    // Single requester, exact latency
    cyc(4'b0001, 4'b0000, 1'b0, 0, 1'b0, 1'b1);
    chk("t1_rom_addr", 32'(rom_addr), 32'h2A3);
    cyc(4'b0000, 4'b0000, 1'b0, -1, 1'b0, 1'b0);
    chk("t1_rsp_not_yet", 32'(rsp_valid), 32'd0);
    cyc(4'b0000, 4'b0000, 1'b0, -1, 1'b0, 1'b0);
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_data",  32'(rsp_data),  32'(rom_f(11'h2A3)));
    idle(2);

    // All four requesting, flat priority: 0,1,2,3,0,...
    do_reset();
    for (int k = 0; k < 8; k++) cyc(4'b1111, 4'b0000, 1'b0, k % 4, 1'b1, 1'b1);
    idle(4);

    // Requester 3 high priority: alternates with requester 0
    do_reset();
    for (int k = 0; k < 6; k++) cyc(4'b1111, 4'b1000, 1'b0, (k % 2 == 0) ? 3 : 0, 1'b1, 1'b1);
    idle(4);

    // frame_tick pointer reset
    do_reset();
    cyc(4'b0100, 4'b0000, 1'b0, 2, 1'b0, 1'b1);   // ptr -> 3
    cyc(4'b1001, 4'b0000, 1'b1, 3, 1'b1, 1'b1);   // grant 3, ptr forced to 0
    cyc(4'b0001, 4'b0000, 1'b0, 0, 1'b0, 1'b1);   // ptr -> 1
    cyc(4'b0010, 4'b0000, 1'b1, 1, 1'b0, 1'b1);   // grant 1, ptr forced to 0
    cyc(4'b0000, 4'b0000, 1'b0, -1, 1'b0, 1'b0);
    cyc(4'b0110, 4'b0000, 1'b0, 1, 1'b1, 1'b1);   // ptr 0 -> requester 1 first
    idle(4);

    // Idle: nothing moves, rom_addr holds the last granted address
    chk("idle_rom_addr_start", 32'(rom_addr), 32'(addr_tab[1]));
    held = rom_addr;
    for (int k = 0; k < 10; k++) begin
      cyc(4'b0000, 4'b0000, 1'b0, -1, 1'b0, 1'b0);
      chk("idle_gnt",       32'(gnt),       32'd0);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_rom_addr",  32'(rom_addr),  32'(held));
    end

    // Reset one cycle after a grant: response must be discarded
    cyc(4'b0001, 4'b0000, 1'b0, 0, 1'b0, 1'b0);
    req = '0;
    @(negedge CLK_50MHZ); #2;
    reset = 1'b1;
    #1;
    chk("midrst_gnt",       32'(gnt),       32'd0);
    chk("midrst_rom_addr",  32'(rom_addr),  32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge CLK_50MHZ);
    #1 reset = 1'b0;
    idle(6);

    chk("grants_outstanding",    32'(gq.size()), 32'd0);
    chk("responses_outstanding", 32'(rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_font_rom_arbiter
`default_nettype wire
